// File: rtl/run_detector_pkg.sv
// Shared definitions for the multi-channel run detector: polarity mode
// encodings and sizing/filter helpers used by every channel.
package run_detector_pkg;

    typedef enum logic [1:0] {
        MODE_EITHER = 2'b00,
        MODE_ONES   = 2'b01,
        MODE_ZEROS  = 2'b10,
        MODE_OFF    = 2'b11
    } mode_e;

    function automatic int run_w(input int run_len);
        return $clog2(run_len + 1);
    endfunction

    // A run of bit b may raise det only if the polarity filter admits b.
    function automatic logic pol_ok(input logic [1:0] mode, input logic b);
        logic ok;
        ok = 1'b0;
        case (mode)
            MODE_EITHER: ok = 1'b1;
            MODE_ONES:   ok = b;
            MODE_ZEROS:  ok = ~b;
            default:     ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/run_detector_chan.sv
// One channel of the run detector: run-length tracker, registered Moore
// detect flag and saturating hit counter.
module run_detector_chan
    import run_detector_pkg::*;
#(
    parameter int RUN_LEN = 2,
    parameter int OVERLAP = 1,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             inp,
    input  logic [1:0]       mode,
    input  logic             cnt_clr,
    output logic             det,
    output logic [CNT_W-1:0] hit_cnt
);

    localparam int RW = run_w(RUN_LEN);
    localparam logic [RW-1:0] RUN_MAX = RW'(RUN_LEN);

    logic [RW-1:0]    run, run_n, run_sat;
    logic             last, last_n;
    logic             hist, hist_n;
    logic             pend, pend_n;
    logic             det_n;
    logic [CNT_W-1:0] cnt_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            run     <= '0;
            last    <= 1'b0;
            hist    <= 1'b0;
            pend    <= 1'b0;
            det     <= 1'b0;
            hit_cnt <= '0;
        end else begin
            run     <= run_n;
            last    <= last_n;
            hist    <= hist_n;
            pend    <= pend_n;
            det     <= det_n;
            hit_cnt <= cnt_n;
        end
    end

    // In non-overlap mode an admitted completed run is consumed so the next
    // bit starts a fresh run; a filtered-out run just saturates.
    always_comb begin
        run_n   = run;
        last_n  = last;
        hist_n  = hist;
        pend_n  = 1'b0;
        run_sat = RW'(1);
        if (in_valid) begin
            if (!hist || (inp != last)) begin
                run_sat = RW'(1);
            end else if (run == RUN_MAX) begin
                run_sat = RUN_MAX;
            end else begin
                run_sat = run + 1'b1;
            end
            last_n = inp;
            hist_n = 1'b1;
            if ((OVERLAP == 0) && (run_sat == RUN_MAX) && pol_ok(mode, inp)) begin
                pend_n = 1'b1;
                run_n  = '0;
                hist_n = 1'b0;
            end else begin
                run_n = run_sat;
            end
        end
    end

    always_comb begin
        det_n = 1'b0;
        cnt_n = hit_cnt;
        if (OVERLAP != 0) begin
            det_n = (run == RUN_MAX) && pol_ok(mode, last);
        end else begin
            det_n = pend;
        end
        if (cnt_clr) begin
            cnt_n = '0;
        end else if (det_n && !det && (hit_cnt != {CNT_W{1'b1}})) begin
            cnt_n = hit_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/run_detector.sv
// Multi-channel run detector top: one independent run_detector_chan per
// channel, with the hit counters flattened onto a single output bus.
module run_detector
    import run_detector_pkg::*;
#(
    parameter int CH      = 1,
    parameter int RUN_LEN = 2,
    parameter int OVERLAP = 1,
    parameter int CNT_W   = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CH-1:0]       in_valid,
    input  logic [CH-1:0]       inp,
    input  logic [1:0]          mode,
    input  logic                cnt_clr,
    output logic [CH-1:0]       det,
    output logic [CH*CNT_W-1:0] hit_cnt
);

    for (genvar c = 0; c < CH; c++) begin : g_chan
        run_detector_chan #(
            .RUN_LEN(RUN_LEN),
            .OVERLAP(OVERLAP),
            .CNT_W  (CNT_W)
        ) u_chan (
            .clk     (clk),
            .rst     (rst),
            .in_valid(in_valid[c]),
            .inp     (inp[c]),
            .mode    (mode),
            .cnt_clr (cnt_clr),
            .det     (det[c]),
            .hit_cnt (hit_cnt[c*CNT_W +: CNT_W])
        );
    end

endmodule

// File: tb/tb_run_detector.sv
// Directed scoreboard bench for run_detector: several parameterisations run
// side by side, each driven through its own sequence of steps.
module tb_run_detector;

    logic clk;
    logic rst, rst5;

    logic v0, d0, c0; logic [1:0] m0; logic det0; logic [7:0]  cnt0;
    logic v1, d1, c1; logic [1:0] m1; logic det1; logic [7:0]  cnt1;
    logic v2, d2, c2; logic [1:0] m2; logic det2; logic [7:0]  cnt2;
    logic v3, d3, c3; logic [1:0] m3; logic det3; logic [7:0]  cnt3;
    logic v4, d4, c4; logic [1:0] m4; logic det4; logic [1:0]  cnt4;
    logic [1:0] v5, d5; logic c5; logic [1:0] m5; logic [1:0] det5; logic [15:0] cnt5;

    typedef struct {
        int          inst;
        string       tag;
        logic [1:0]  det;
        logic [15:0] cnt;
    } exp_t;

    exp_t sb[$];
    int   checks;
    int   errors;

    run_detector #(.CH(1), .RUN_LEN(2), .OVERLAP(1), .CNT_W(8)) u0 (
        .clk(clk), .rst(rst), .in_valid(v0), .inp(d0), .mode(m0),
        .cnt_clr(c0), .det(det0), .hit_cnt(cnt0));
    run_detector #(.CH(1), .RUN_LEN(4), .OVERLAP(1), .CNT_W(8)) u1 (
        .clk(clk), .rst(rst), .in_valid(v1), .inp(d1), .mode(m1),
        .cnt_clr(c1), .det(det1), .hit_cnt(cnt1));
    run_detector #(.CH(1), .RUN_LEN(3), .OVERLAP(0), .CNT_W(8)) u2 (
        .clk(clk), .rst(rst), .in_valid(v2), .inp(d2), .mode(m2),
        .cnt_clr(c2), .det(det2), .hit_cnt(cnt2));
    run_detector #(.CH(1), .RUN_LEN(3), .OVERLAP(1), .CNT_W(8)) u3 (
        .clk(clk), .rst(rst), .in_valid(v3), .inp(d3), .mode(m3),
        .cnt_clr(c3), .det(det3), .hit_cnt(cnt3));
    run_detector #(.CH(1), .RUN_LEN(2), .OVERLAP(0), .CNT_W(2)) u4 (
        .clk(clk), .rst(rst), .in_valid(v4), .inp(d4), .mode(m4),
        .cnt_clr(c4), .det(det4), .hit_cnt(cnt4));
    run_detector #(.CH(2), .RUN_LEN(3), .OVERLAP(1), .CNT_W(8)) u5 (
        .clk(clk), .rst(rst5), .in_valid(v5), .inp(d5), .mode(m5),
        .cnt_clr(c5), .det(det5), .hit_cnt(cnt5));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [1:0] obs_det(input int inst);
        case (inst)
            0: return {1'b0, det0};
            1: return {1'b0, det1};
            2: return {1'b0, det2};
            3: return {1'b0, det3};
            4: return {1'b0, det4};
            5: return det5;
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic [15:0] obs_cnt(input int inst);
        case (inst)
            0: return {8'h00, cnt0};
            1: return {8'h00, cnt1};
            2: return {8'h00, cnt2};
            3: return {8'h00, cnt3};
            4: return {14'h0000, cnt4};
            5: return cnt5;
            default: return 16'h0000;
        endcase
    endfunction

    task automatic drive(input int inst, input logic [1:0] vv, input logic [1:0] dd);
        case (inst)
            0: begin v0 = vv[0]; d0 = dd[0]; end
            1: begin v1 = vv[0]; d1 = dd[0]; end
            2: begin v2 = vv[0]; d2 = dd[0]; end
            3: begin v3 = vv[0]; d3 = dd[0]; end
            4: begin v4 = vv[0]; d4 = dd[0]; end
            5: begin v5 = vv;    d5 = dd;    end
            default: ;
        endcase
    endtask

    task automatic pushExp(input int inst, input string tag,
                           input logic [1:0] ed, input logic [15:0] ec);
        exp_t e;
        e.inst = inst;
        e.tag  = tag;
        e.det  = ed;
        e.cnt  = ec;
        sb.push_back(e);
    endtask

    task automatic checkOutput();
        exp_t        e;
        logic [1:0]  od;
        logic [15:0] oc;
        while (sb.size() > 0) begin
            e  = sb.pop_front();
            od = obs_det(e.inst);
            oc = obs_cnt(e.inst);
            checks++;
            assert (od === e.det) else begin
                errors++;
                $error("[TB] FAIL %s det observed=%0h expected=%0h", e.tag, od, e.det);
            end
            checks++;
            assert (oc === e.cnt) else begin
                errors++;
                $error("[TB] FAIL %s hit_cnt observed=%0h expected=%0h", e.tag, oc, e.cnt);
            end
        end
    endtask

    // One edge of stimulus on one instance; expectation is what follows the edge.
    task automatic applyStimulus(input int inst, input string tag,
                                 input logic [1:0] vv, input logic [1:0] dd,
                                 input logic [1:0] ed, input logic [15:0] ec);
        drive(inst, vv, dd);
        pushExp(inst, tag, ed, ec);
        @(posedge clk);
        #1;
        drive(inst, 2'b00, 2'b00);
        checkOutput();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1; rst5 = 1'b1;
        v0 = 0; d0 = 0; c0 = 0; m0 = 2'b00;
        v1 = 0; d1 = 0; c1 = 0; m1 = 2'b01;
        v2 = 0; d2 = 0; c2 = 0; m2 = 2'b00;
        v3 = 0; d3 = 0; c3 = 0; m3 = 2'b00;
        v4 = 0; d4 = 0; c4 = 0; m4 = 2'b00;
        v5 = 0; d5 = 0; c5 = 0; m5 = 2'b00;

        @(posedge clk);
        @(posedge clk);
        #1;
        for (int i = 0; i < 6; i++) pushExp(i, "reset", 2'b00, 16'h0000);
        checkOutput();
        rst = 1'b0; rst5 = 1'b0;

        // Legacy-equivalent case: 1,1,1,0,0 then an idle cycle
        applyStimulus(0, "A1", 2'b01, 2'b01, 2'b00, 16'd0);
        applyStimulus(0, "A2", 2'b01, 2'b01, 2'b00, 16'd0);
        applyStimulus(0, "A3", 2'b01, 2'b01, 2'b01, 16'd1);
        applyStimulus(0, "A4", 2'b01, 2'b00, 2'b01, 16'd1);
        applyStimulus(0, "A5", 2'b01, 2'b00, 2'b00, 16'd1);
        applyStimulus(0, "A6", 2'b00, 2'b00, 2'b01, 16'd2);

        // Ones-only filter, RUN_LEN=4, then mode switched off and back on
        for (int i = 0; i < 5; i++) applyStimulus(1, "B_zero", 2'b01, 2'b00, 2'b00, 16'd0);
        for (int i = 0; i < 4; i++) applyStimulus(1, "B_one", 2'b01, 2'b01, 2'b00, 16'd0);
        applyStimulus(1, "B10", 2'b00, 2'b00, 2'b01, 16'd1);
        applyStimulus(1, "B11", 2'b00, 2'b00, 2'b01, 16'd1);
        m1 = 2'b11;
        applyStimulus(1, "B_off", 2'b00, 2'b00, 2'b00, 16'd1);
        m1 = 2'b00;
        applyStimulus(1, "B_on", 2'b00, 2'b00, 2'b01, 16'd2);

        // Non-overlap RUN_LEN=3: nine ones give pulses at edges 4, 7, 10
        applyStimulus(2, "C1", 2'b01, 2'b01, 2'b00, 16'd0);
        applyStimulus(2, "C2", 2'b01, 2'b01, 2'b00, 16'd0);
        applyStimulus(2, "C3", 2'b01, 2'b01, 2'b00, 16'd0);
        applyStimulus(2, "C4", 2'b01, 2'b01, 2'b01, 16'd1);
        applyStimulus(2, "C5", 2'b01, 2'b01, 2'b00, 16'd1);
        applyStimulus(2, "C6", 2'b01, 2'b01, 2'b00, 16'd1);
        applyStimulus(2, "C7", 2'b01, 2'b01, 2'b01, 16'd2);
        applyStimulus(2, "C8", 2'b01, 2'b01, 2'b00, 16'd2);
        applyStimulus(2, "C9", 2'b01, 2'b01, 2'b00, 16'd2);
        applyStimulus(2, "C10", 2'b00, 2'b00, 2'b01, 16'd3);
        // Filtered-out zero run saturates silently; a following ones run pulses
        m2 = 2'b01;
        for (int i = 0; i < 4; i++) applyStimulus(2, "C_polz", 2'b01, 2'b00, 2'b00, 16'd3);
        for (int i = 0; i < 3; i++) applyStimulus(2, "C_polo", 2'b01, 2'b01, 2'b00, 16'd3);
        applyStimulus(2, "C_polp", 2'b00, 2'b00, 2'b01, 16'd4);
        applyStimulus(2, "C_pole", 2'b00, 2'b00, 2'b00, 16'd4);

        // Gap in in_valid holds the run; an intervening 0 breaks it
        applyStimulus(3, "D1", 2'b01, 2'b01, 2'b00, 16'd0);
        applyStimulus(3, "D2", 2'b01, 2'b01, 2'b00, 16'd0);
        applyStimulus(3, "D3_gap", 2'b00, 2'b00, 2'b00, 16'd0);
        applyStimulus(3, "D4", 2'b01, 2'b01, 2'b00, 16'd0);
        applyStimulus(3, "D5", 2'b00, 2'b00, 2'b01, 16'd1);
        applyStimulus(3, "D6", 2'b01, 2'b00, 2'b01, 16'd1);
        applyStimulus(3, "D7", 2'b01, 2'b01, 2'b00, 16'd1);
        applyStimulus(3, "D8", 2'b01, 2'b01, 2'b00, 16'd1);
        applyStimulus(3, "D9", 2'b01, 2'b00, 2'b00, 16'd1);
        applyStimulus(3, "D10", 2'b01, 2'b01, 2'b00, 16'd1);
        applyStimulus(3, "D11", 2'b00, 2'b00, 2'b00, 16'd1);

        // 2-bit counter saturation, then clear colliding with a pulse
        for (int i = 1; i <= 12; i++) begin
            applyStimulus(4, "E_run", 2'b01, 2'b01, (i % 2 == 1 && i > 1) ? 2'b01 : 2'b00,
                          (i < 3) ? 16'd0 : (i < 5) ? 16'd1 : (i < 7) ? 16'd2 : 16'd3);
        end
        c4 = 1'b1;
        applyStimulus(4, "E_clr", 2'b00, 2'b00, 2'b01, 16'd0);
        c4 = 1'b0;
        applyStimulus(4, "E_post", 2'b00, 2'b00, 2'b00, 16'd0);

        // Two channels, reset mid-run, independent patterns afterwards
        applyStimulus(5, "F1", 2'b11, 2'b01, 2'b00, 16'h0000);
        applyStimulus(5, "F2", 2'b11, 2'b01, 2'b00, 16'h0000);
        applyStimulus(5, "F3", 2'b10, 2'b00, 2'b00, 16'h0000);
        rst5 = 1'b1;
        applyStimulus(5, "F4_rst", 2'b01, 2'b01, 2'b00, 16'h0000);
        rst5 = 1'b0;
        applyStimulus(5, "F5", 2'b11, 2'b11, 2'b00, 16'h0000);
        applyStimulus(5, "F6", 2'b11, 2'b11, 2'b00, 16'h0000);
        applyStimulus(5, "F7", 2'b11, 2'b01, 2'b00, 16'h0000);
        applyStimulus(5, "F8", 2'b10, 2'b00, 2'b01, 16'h0001);
        applyStimulus(5, "F9", 2'b10, 2'b00, 2'b01, 16'h0001);
        applyStimulus(5, "F10", 2'b00, 2'b00, 2'b11, 16'h0101);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
